// File: rtl/hea_gf_mul_seq.sv
// Iterative GF(2^W) multiplier with a programmable reduction polynomial.
// Consumes DIGIT multiplier bits per cycle, MSB first (Horner scheme), so a
// product takes W/DIGIT cycles in RUN. valid/ready handshakes on both sides;
// one operation in flight at a time.
module hea_gf_mul_seq #(
   parameter int           W     = 8,
   parameter logic [W:0]   POLY  = 'h11B,
   parameter int           DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] p
);

   localparam int N  = W / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((W < 2) || (DIGIT < 1) || (W % DIGIT != 0) || (POLY[W] != 1'b1)) begin : g_bad_params
         $error("hea_gf_mul_seq: need W>=2, W%%DIGIT==0 and POLY[W]==1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    p_q, p_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    step;

   // One Horner digit: for each bit (MSB first) multiply acc by x modulo
   // POLY, then add the multiplicand when the multiplier bit is set.
   function automatic logic [W-1:0] digit_step(input logic [W-1:0] acc,
                                               input logic [W-1:0] mc,
                                               input logic [DIGIT-1:0] bits);
      logic [W-1:0] r;
      r = acc;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         r = {r[W-2:0], 1'b0} ^ (r[W-1] ? POLY[W-1:0] : '0);
         if (bits[i]) r = r ^ mc;
      end
      return r;
   endfunction

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign p         = p_q;

   // Next-state and datapath update; clr overrides every other event.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      step    = digit_step(acc_q, a_q, b_q[W-1 -: DIGIT]);
      if (clr) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         p_d     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_d     = a;
                  b_d     = b;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               acc_d = step;
               b_d   = b_q << DIGIT;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  p_d     = step;
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hea_gf_mul_seq.sv
// Bench for hea_gf_mul_seq: three parameterisations (GF256 digit 1,
// GF256 digit 4, GF16 digit 2) checked every cycle against a transaction
// level model, plus directed literal vectors.
module tb_hea_gf_mul_seq;

   localparam int NI = 3;
   localparam int WS[NI]         = '{8, 8, 4};
   localparam int NS[NI]         = '{8, 2, 2};
   localparam logic [8:0] PS[NI] = '{9'h11B, 9'h11B, 9'h013};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NI-1:0] clr = '0;
   logic [NI-1:0] in_valid = '0;
   logic [NI-1:0] out_ready = '0;
   logic [NI-1:0] in_ready_s;
   logic [NI-1:0] out_valid_s;
   logic [7:0] a_s[NI];
   logic [7:0] b_s[NI];
   logic [7:0] p0, p1;
   logic [3:0] p2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hea_gf_mul_seq #(.W(8), .POLY(9'h11B), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready_s[0]),
      .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready[0]), .p(p0));
   hea_gf_mul_seq #(.W(8), .POLY(9'h11B), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready_s[1]),
      .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready[1]), .p(p1));
   hea_gf_mul_seq #(.W(4), .POLY(5'h13), .DIGIT(2)) u_g16 (
      .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready_s[2]),
      .a(a_s[2][3:0]), .b(b_s[2][3:0]), .out_valid(out_valid_s[2]), .out_ready(out_ready[2]), .p(p2));

   function automatic logic [7:0] pk(int k);
      case (k)
         0:       return p0;
         1:       return p1;
         default: return {4'h0, p2};
      endcase
   endfunction

   // Reference: full carry-less product, then polynomial long division.
   function automatic logic [7:0] gfmul(logic [7:0] av, logic [7:0] bv, int w, logic [8:0] poly);
      logic [15:0] prod;
      logic [15:0] am;
      logic [15:0] bm;
      prod = '0;
      am   = {8'h00, av} & ((16'h1 << w) - 16'h1);
      bm   = {8'h00, bv} & ((16'h1 << w) - 16'h1);
      for (int i = 0; i < w; i++)
         if (bm[i]) prod = prod ^ (am << i);
      for (int i = 2 * w - 2; i >= w; i--)
         if (prod[i]) prod = prod ^ ({7'h00, poly} << (i - w));
      return prod[7:0];
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: remaining latency, done flag, expected p.
   int         m_left[NI] = '{0, 0, 0};
   logic       m_done[NI] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] m_exp[NI]  = '{8'h0, 8'h0, 8'h0};
   logic [7:0] m_p[NI]    = '{8'h0, 8'h0, 8'h0};
   int         m_acc[NI]  = '{0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            m_left[k] = 0; m_done[k] = 1'b0; m_p[k] = 8'h0;
         end else if (clr[k]) begin
            m_left[k] = 0; m_done[k] = 1'b0; m_p[k] = 8'h0;
         end else if (m_done[k]) begin
            if (out_ready[k]) m_done[k] = 1'b0;
         end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_done[k] = 1'b1;
               m_p[k]    = m_exp[k];
            end
         end else if (in_valid[k]) begin
            m_left[k] = NS[k];
            m_exp[k]  = gfmul(a_s[k], b_s[k], WS[k], PS[k]);
            m_acc[k]++;
         end
      end
   end

   // Compare every instance against the model on each falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("u%0d_in_ready", k), in_ready_s[k], (m_left[k] == 0) && !m_done[k]);
         chk($sformatf("u%0d_out_valid", k), out_valid_s[k], m_done[k]);
         chk($sformatf("u%0d_p", k), pk(k), m_p[k]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed op: checks latency and a hand-computed literal product.
   task automatic do_op(int k, logic [7:0] av, logic [7:0] bv, logic [7:0] ex, string nm);
      int cyc;
      out_ready[k] = 1'b0;
      a_s[k] = av; b_s[k] = bv; in_valid[k] = 1'b1;
      chk({nm, "_ready"}, in_ready_s[k], 1'b1);
      tick();
      in_valid[k] = 1'b0;
      a_s[k] = 8'hA5; b_s[k] = 8'h5A;
      cyc = 0;
      while (!out_valid_s[k] && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({nm, "_latency"}, cyc, NS[k]);
      chk({nm, "_p"}, pk(k), ex);
      out_ready[k] = 1'b1;
      tick();
      chk({nm, "_vld_drop"}, out_valid_s[k], 1'b0);
      out_ready[k] = 1'b0;
   endtask

   initial begin
      int cyc;
      for (int k = 0; k < NI; k++) begin a_s[k] = 8'h0; b_s[k] = 8'h0; end

      // Literal pins on the model itself.
      chk("model_57x83", gfmul(8'h57, 8'h83, 8, 9'h11B), 8'hC1);
      chk("model_57x13", gfmul(8'h57, 8'h13, 8, 9'h11B), 8'hFE);
      chk("model_80x02", gfmul(8'h80, 8'h02, 8, 9'h11B), 8'h1B);
      chk("model_7xB",   gfmul(8'h07, 8'h0B, 4, 9'h013), 8'h04);

      #12;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_u%0d_ready", k), in_ready_s[k], 1'b1);
         chk($sformatf("rst_u%0d_vld", k), out_valid_s[k], 1'b0);
         chk($sformatf("rst_u%0d_p", k), pk(k), 8'h0);
      end
      rst_n = 1'b1;
      tick();

      do_op(0, 8'h57, 8'h83, 8'hC1, "d1_57x83");
      do_op(1, 8'h57, 8'h13, 8'hFE, "d4_57x13");
      do_op(1, 8'h80, 8'h02, 8'h1B, "d4_80x02");
      do_op(2, 8'h07, 8'h0B, 8'h04, "g16_7xB");
      do_op(2, 8'h00, 8'h0F, 8'h00, "g16_0xF");
      do_op(2, 8'h09, 8'h01, 8'h09, "g16_9x1");
      do_op(0, 8'h00, 8'h83, 8'h00, "d1_a0");
      do_op(0, 8'hC3, 8'h01, 8'hC3, "d1_b1");

      // Backpressure: hold DONE for 5 cycles with a new request pending.
      a_s[0] = 8'h57; b_s[0] = 8'h83; in_valid[0] = 1'b1;
      tick();
      a_s[0] = 8'h80; b_s[0] = 8'h02;
      cyc = 0;
      while (!out_valid_s[0] && cyc < 40) begin tick(); cyc++; end
      chk("bp_latency", cyc, 8);
      for (int i = 0; i < 5; i++) begin
         chk("bp_p", p0, 8'hC1);
         chk("bp_vld", out_valid_s[0], 1'b1);
         chk("bp_ready", in_ready_s[0], 1'b0);
         tick();
      end
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk("bp_vld_drop", out_valid_s[0], 1'b0);
      chk("bp_idle_ready", in_ready_s[0], 1'b1);
      tick();
      in_valid[0] = 1'b0;
      cyc = 0;
      while (!out_valid_s[0] && cyc < 40) begin tick(); cyc++; end
      chk("bp_next_latency", cyc, 8);
      chk("bp_next_p", p0, 8'h1B);
      out_ready[0] = 1'b1; tick(); out_ready[0] = 1'b0;

      // clr during the third RUN cycle, with in_valid asserted alongside.
      a_s[0] = 8'h57; b_s[0] = 8'h83; in_valid[0] = 1'b1;
      tick();
      tick(); tick();
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0; in_valid[0] = 1'b0;
      chk("clr_ready", in_ready_s[0], 1'b1);
      chk("clr_vld", out_valid_s[0], 1'b0);
      chk("clr_p", p0, 8'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("clr_no_vld", out_valid_s[0], 1'b0);
      end
      do_op(0, 8'h57, 8'h83, 8'hC1, "clr_after");

      // Asynchronous reset mid-RUN.
      a_s[0] = 8'h57; b_s[0] = 8'h83; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", in_ready_s[0], 1'b1);
      chk("arst_vld", out_valid_s[0], 1'b0);
      chk("arst_p", p0, 8'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      do_op(0, 8'h57, 8'h83, 8'hC1, "arst_after");

      // Random traffic on all three instances concurrently.
      cyc = 0;
      for (int k = 0; k < NI; k++) m_acc[k] = 0;
      while ((m_acc[0] < 334 || m_acc[1] < 334 || m_acc[2] < 334) && cyc < 30000) begin
         for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'($urandom_range(0, 1));
            out_ready[k] = 1'($urandom_range(0, 1));
            clr[k]       = ($urandom_range(0, 299) == 0);
            a_s[k]       = 8'($urandom);
            b_s[k]       = 8'($urandom);
         end
         tick();
         cyc++;
      end
      in_valid = '0; clr = '0; out_ready = '1;
      chk("rand_ops", (m_acc[0] + m_acc[1] + m_acc[2]) >= 1000, 1'b1);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
